// File: rtl/reg_wb_arb.sv
// Two-requester register-file writeback arbiter with round-robin tie-break,
// registered write port and a pending-write scoreboard.
module reg_wb_arb #(
    parameter logic LAST_INIT = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       a_valid_i,
    input  logic [1:0] a_nd_i,
    input  logic [7:0] a_di_i,
    output logic       a_ready_o,
    input  logic       b_valid_i,
    input  logic [1:0] b_nd_i,
    input  logic [7:0] b_di_i,
    output logic       b_ready_o,
    input  logic       issue_i,
    input  logic [1:0] issue_nd_i,
    output logic [1:0] nd_o,
    output logic [7:0] di_o,
    output logic       reg_we_o,
    output logic [3:0] pend_o
);

    logic       last_q, last_d;
    logic       we_q, we_d;
    logic [1:0] nd_q, nd_d;
    logic [7:0] di_q, di_d;
    logic [3:0] pend_q, pend_d;
    logic       grant_a_s, grant_b_s;
    logic [3:0] clr_mask_s, set_mask_s;

    // Grant selection; last_q = 1 means B was granted last, so A wins a tie.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (rst_i) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_valid_i && b_valid_i) begin
            if (last_q) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (a_valid_i) begin
            grant_a_s = 1'b1;
        end else if (b_valid_i) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Next-state for write port, arbitration history and scoreboard.
    always_comb begin
        last_d     = last_q;
        we_d       = grant_a_s | grant_b_s;
        nd_d       = nd_q;
        di_d       = di_q;
        clr_mask_s = 4'b0000;
        set_mask_s = 4'b0000;
        if (grant_a_s) begin
            nd_d       = a_nd_i;
            di_d       = a_di_i;
            last_d     = 1'b0;
            clr_mask_s = 4'b0001 << a_nd_i;
        end else if (grant_b_s) begin
            nd_d       = b_nd_i;
            di_d       = b_di_i;
            last_d     = 1'b1;
            clr_mask_s = 4'b0001 << b_nd_i;
        end else begin
            clr_mask_s = 4'b0000;
        end
        if (issue_i) begin
            set_mask_s = 4'b0001 << issue_nd_i;
        end else begin
            set_mask_s = 4'b0000;
        end
        // A same-cycle issue to the register being written keeps it pending.
        pend_d = (pend_q & ~clr_mask_s) | set_mask_s;
    end

    // State registers with synchronous reset; issue and grants are dropped in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= LAST_INIT;
            we_q   <= 1'b0;
            nd_q   <= 2'b00;
            di_q   <= 8'h00;
            pend_q <= 4'b0000;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            nd_q   <= nd_d;
            di_q   <= di_d;
            pend_q <= pend_d;
        end
    end

    assign a_ready_o = grant_a_s;
    assign b_ready_o = grant_b_s;
    assign reg_we_o  = we_q;
    assign nd_o      = nd_q;
    assign di_o      = di_q;
    assign pend_o    = pend_q;

endmodule

// File: tb/tb_reg_wb_arb.sv
// Directed self-checking bench for reg_wb_arb: reset, single grants,
// round-robin alternation, scoreboard set/clear and mid-stream reset.
module tb_reg_wb_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, issue;
    logic [1:0] a_nd, b_nd, issue_nd;
    logic [7:0] a_di, b_di;
    logic       a_ready, b_ready, reg_we;
    logic [1:0] nd;
    logic [7:0] di;
    logic [3:0] pend;

    int checks = 0;
    int errors = 0;

    reg_wb_arb #(.LAST_INIT(1'b1)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .a_valid_i  (a_valid),
        .a_nd_i     (a_nd),
        .a_di_i     (a_di),
        .a_ready_o  (a_ready),
        .b_valid_i  (b_valid),
        .b_nd_i     (b_nd),
        .b_di_i     (b_di),
        .b_ready_o  (b_ready),
        .issue_i    (issue),
        .issue_nd_i (issue_nd),
        .nd_o       (nd),
        .di_o       (di),
        .reg_we_o   (reg_we),
        .pend_o     (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] a_cnt;
        logic [7:0] b_cnt;
        logic       exp_a;

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; issue = 1'b0;
        a_nd = 2'd0; b_nd = 2'd0; issue_nd = 2'd0; a_di = 8'h00; b_di = 8'h00;
        tick();
        tick();
        check("rst_we", {31'd0, reg_we}, 32'd0);
        check("rst_nd", {30'd0, nd}, 32'd0);
        check("rst_di", {24'd0, di}, 32'd0);
        check("rst_pend", {28'd0, pend}, 32'd0);
        a_valid = 1'b1; issue = 1'b1; issue_nd = 2'd1;
        #1;
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        check("rst_discard_pend", {28'd0, pend}, 32'd0);
        check("rst_discard_we", {31'd0, reg_we}, 32'd0);

        // Single A write
        rst = 1'b0; issue = 1'b0; a_valid = 1'b1; a_nd = 2'd2; a_di = 8'h5A;
        #1;
        check("single_a_ready", {31'd0, a_ready}, 32'd1);
        check("single_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("single_we", {31'd0, reg_we}, 32'd1);
        check("single_nd", {30'd0, nd}, 32'd2);
        check("single_di", {24'd0, di}, 32'h5A);
        tick();
        check("idle_we", {31'd0, reg_we}, 32'd0);
        check("idle_nd_hold", {30'd0, nd}, 32'd2);

        // Tie after reset: A first, then B
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_nd = 2'd1; a_di = 8'h11;
        b_valid = 1'b1; b_nd = 2'd3; b_di = 8'h33;
        #1;
        check("tie_a_ready", {31'd0, a_ready}, 32'd1);
        check("tie_b_wait", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("tie_we1", {31'd0, reg_we}, 32'd1);
        check("tie_nd1", {30'd0, nd}, 32'd1);
        check("tie_di1", {24'd0, di}, 32'h11);
        #1;
        check("tie_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("tie_we2", {31'd0, reg_we}, 32'd1);
        check("tie_nd2", {30'd0, nd}, 32'd3);
        check("tie_di2", {24'd0, di}, 32'h33);
        tick();
        check("tie_we3", {31'd0, reg_we}, 32'd0);
        check("tie_di_hold", {24'd0, di}, 32'h33);
        tick();

        // Continuous contention: B was last, so A,B,A,B,A,B
        a_cnt = 8'd0; b_cnt = 8'd0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_nd = a_cnt[1:0]; a_di = 8'hA0 + a_cnt;
            b_nd = b_cnt[1:0]; b_di = 8'hB0 + b_cnt;
            exp_a = (k % 2 == 0);
            #1;
            check("rr_a_ready", {31'd0, a_ready}, {31'd0, exp_a});
            check("rr_b_ready", {31'd0, b_ready}, {31'd0, ~exp_a});
            check("rr_one_hot", {31'd0, a_ready & b_ready}, 32'd0);
            tick();
            check("rr_we", {31'd0, reg_we}, 32'd1);
            if (exp_a) begin
                check("rr_di_a", {24'd0, di}, {24'd0, 8'hA0 + a_cnt});
                a_cnt = a_cnt + 8'd1;
            end else begin
                check("rr_di_b", {24'd0, di}, {24'd0, 8'hB0 + b_cnt});
                b_cnt = b_cnt + 8'd1;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("rr_pend_unchanged", {28'd0, pend}, 32'd0);

        // Scoreboard set then clear by B write
        issue = 1'b1; issue_nd = 2'd2;
        tick();
        issue = 1'b0;
        check("sb_set", {28'd0, pend}, 32'h4);
        tick();
        tick();
        b_valid = 1'b1; b_nd = 2'd2; b_di = 8'h77;
        #1;
        check("sb_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("sb_clr", {28'd0, pend}, 32'h0);
        check("sb_we", {31'd0, reg_we}, 32'd1);
        check("sb_nd", {30'd0, nd}, 32'd2);
        check("sb_di", {24'd0, di}, 32'h77);

        // Simultaneous issue and write to register 0: set wins
        issue = 1'b1; issue_nd = 2'd0;
        tick();
        check("sw_pre", {28'd0, pend}, 32'h1);
        a_valid = 1'b1; a_nd = 2'd0; a_di = 8'h42;
        #1;
        check("sw_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        issue = 1'b0; a_valid = 1'b0;
        check("sw_pend", {28'd0, pend}, 32'h1);
        check("sw_we", {31'd0, reg_we}, 32'd1);
        check("sw_nd", {30'd0, nd}, 32'd0);
        check("sw_di", {24'd0, di}, 32'h42);

        // Mid-stream reset with PEND=1010
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue = 1'b1; issue_nd = 2'd1;
        tick();
        issue_nd = 2'd3;
        tick();
        issue = 1'b0;
        check("mr_pend_pre", {28'd0, pend}, 32'hA);
        rst = 1'b1; a_valid = 1'b1; a_nd = 2'd1; a_di = 8'hC3;
        #1;
        check("mr_a_ready_rst", {31'd0, a_ready}, 32'd0);
        tick();
        check("mr_we", {31'd0, reg_we}, 32'd0);
        check("mr_pend", {28'd0, pend}, 32'h0);
        check("mr_di", {24'd0, di}, 32'h0);
        rst = 1'b0; b_valid = 1'b1; b_nd = 2'd2; b_di = 8'hD4;
        #1;
        check("mr_a_ready", {31'd0, a_ready}, 32'd1);
        check("mr_b_wait", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("mr_we_a", {31'd0, reg_we}, 32'd1);
        check("mr_nd_a", {30'd0, nd}, 32'd1);
        check("mr_di_a", {24'd0, di}, 32'hC3);
        #1;
        check("mr_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("mr_nd_b", {30'd0, nd}, 32'd2);
        check("mr_di_b", {24'd0, di}, 32'hD4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 Parameter: LAST_INIT, 1'b1, requester treated as last-granted after reset (1 = B, so A wins the first tie).
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 A_VALID  input  1  requester A (ALU writeback) has a write pending.
REQ-005 A_ND  input  2  requester A destination register id.
REQ-006 A_DI  input  8  requester A write data.
REQ-007 A_READY  output  1  requester A write accepted this cycle.
REQ-008 B_VALID  input  1  requester B (load writeback) has a write pending.
REQ-009 B_ND  input  2  requester B destination register id.
REQ-010 B_DI  input  8  requester B write data.
REQ-011 B_READY  output  1  requester B write accepted this cycle.
REQ-012 ISSUE  input  1  an instruction targeting ISSUE_ND was issued; mark register pending.
REQ-013 ISSUE_ND  input  2  register id marked pending by ISSUE.
REQ-014 ND  output  2  register-file write id, registered.
REQ-015 DI  output  8  register-file write data, registered.
REQ-016 REG_WE  output  1  register-file write enable, registered.
REQ-017 PEND  output  4  scoreboard; PEND[n]=1 means register n has an outstanding write.

Function
REQ-018 Handshake: a write is accepted in the cycle X_VALID && X_READY; the requester holds VALID/ND/DI stable until accepted.
REQ-019 At most one of A_READY, B_READY SHALL be high per cycle; READY SHALL be high only while the matching VALID is high (combinational from VALID and LAST).
REQ-020 Only A valid -> grant A; only B valid -> grant B; neither -> no grant, REG_WE=0 next cycle.
REQ-021 Both valid -> grant the requester not recorded in LAST (round-robin); LAST updates to the granted requester on every grant, unchanged when idle.
REQ-022 Latency: an accepted write appears on ND/DI with REG_WE=1 exactly one cycle after acceptance; back-to-back grants produce REG_WE high on consecutive cycles.
REQ-023 When REG_WE=0, ND/DI SHALL hold their previous values.
REQ-024 Scoreboard set: ISSUE=1 sets PEND[ISSUE_ND] at the next edge.
REQ-025 Scoreboard clear: an accepted write to register n clears PEND[n] at the same edge that loads REG_WE (i.e. PEND drops in the cycle REG_WE appears).
REQ-026 Simultaneous ISSUE to n and accepted write to n in one cycle: set wins, PEND[n]=1.
REQ-027 Accepted write to a register whose PEND bit is 0: write proceeds normally, PEND unchanged.
REQ-028 Both requesters targeting the same ND in one cycle: only the granted write proceeds; the other waits its turn, no merging.

Reset
REQ-029 While Reset=1 at an edge: REG_WE=0, ND=2'b0, DI=8'b0, PEND=4'b0, LAST=LAST_INIT.
REQ-030 While Reset=1, A_READY and B_READY SHALL be 0; ISSUE and requests in that cycle are discarded.
REQ-031 Reset asserted mid-stream drops any grant of that cycle; the first cycle after reset arbitrates from LAST_INIT.

Verification
REQ-032 Reset, then A_VALID=1 A_ND=2 A_DI=8'h5A alone -> A_READY=1 same cycle; next cycle REG_WE=1 ND=2 DI=8'h5A.
REQ-033 After reset, A and B both held valid (A: ND=1 DI=8'h11, B: ND=3 DI=8'h33) for 4 cycles, each dropping VALID after acceptance -> grants A, B; REG_WE sequence 1,1,0; ND sequence 1,3.
REQ-034 Both valid continuously with new data each accept for 6 cycles -> grants alternate A,B,A,B,A,B; never both READY high.
REQ-035 ISSUE ND=2 at cycle t -> PEND=4'b0100 at t+1; B write ND=2 accepted at t+3 -> PEND=4'b0000 at t+4 with REG_WE=1.
REQ-036 ISSUE ND=0 and A write ND=0 accepted same cycle with PEND[0]=1 -> PEND[0] remains 1, REG_WE=1 ND=0 next cycle.
REQ-037 Reset asserted in the cycle A is valid with PEND=4'b1010 -> A_READY=0, next cycle REG_WE=0 PEND=0; A then granted one cycle after Reset drops.
